// File: rtl/pcm_mem_reader.sv
// Reads back the 2048-word PCM on-chip memory under NIOS control, streams the words
// out with sop/eop and checks each one against the alternating fill pattern.
module pcm_mem_reader #(
   parameter int unsigned       ADDR_W   = 11,
   parameter int unsigned       DATA_W   = 16,
   parameter logic [DATA_W-1:0] PAT_EVEN = 16'h0705,
   parameter logic [DATA_W-1:0] PAT_ODD  = 16'h0806
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        pccm_ctl_con_export,
   output logic [3:0]        pccm_rsp_con_export,
   output logic [ADDR_W-1:0] pcm_mem_mm_address,
   output logic              pcm_mem_mm_chipselect,
   output logic              pcm_mem_mm_clken,
   output logic              pcm_mem_mm_write,
   input  logic [DATA_W-1:0] pcm_mem_mm_readdata,
   output logic [DATA_W-1:0] pcm_mem_mm_writedata,
   output logic [1:0]        pcm_mem_mm_byteenable,
   output logic [DATA_W-1:0] pcm_st_data,
   output logic              pcm_st_valid,
   input  logic              pcm_st_ready,
   output logic              pcm_st_sop,
   output logic              pcm_st_eop,
   output logic [11:0]       mismatch_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] CMD_START = 4'h2;
   localparam logic [3:0] CMD_ACK   = 4'h4;
   localparam logic [3:0] CMD_ABORT = 4'h8;

   localparam logic [11:0] MAX_ERRS = 12'(2 ** ADDR_W);

   typedef struct packed {
      logic              sop;
      logic              eop;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W:0]   issue_addr_q, issue_addr_d;   // extra MSB marks "all words issued"
   logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
   logic              inflight_q, inflight_d;
   logic [1:0]        count_q, count_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [11:0]       err_cnt_q, err_cnt_d;
   logic [ADDR_W-1:0] first_err_q, first_err_d;
   entry_t            fifo_q [2];

   logic   in_run, abort, start, ack;
   logic   not_empty, pop, push, issue, word_bad;
   entry_t head, push_entry;

   always_comb begin
      in_run    = (state_q == S_RUN);
      abort     = in_run && (pccm_ctl_con_export == CMD_ABORT);
      start     = (state_q == S_IDLE) && (pccm_ctl_con_export == CMD_START);
      ack       = (state_q == S_DONE) && (pccm_ctl_con_export == CMD_ACK);
      not_empty = (count_q != 2'd0);
      head      = fifo_q[rd_ptr_q];
      pop       = in_run && !abort && not_empty && pcm_st_ready;
      push      = in_run && !abort && inflight_q;
      // Keep buffered + in-flight words within the two FIFO slots after this cycle.
      issue     = in_run && !abort && !issue_addr_q[ADDR_W] &&
                  (({1'b0, count_q} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, pop}));

      push_entry.sop  = (ret_addr_q == '0);
      push_entry.eop  = (ret_addr_q == '1);
      push_entry.data = pcm_mem_mm_readdata;
      word_bad        = pcm_mem_mm_readdata != (ret_addr_q[0] ? PAT_ODD : PAT_EVEN);
   end

   // NOTE: every variable gets its hold value first, so no branch can leave one
   // unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      issue_addr_d = issue_addr_q;
      ret_addr_d   = ret_addr_q;
      inflight_d   = inflight_q;
      count_d      = count_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      err_cnt_d    = err_cnt_q;
      first_err_d  = first_err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_RUN;
               issue_addr_d = '0;
               ret_addr_d   = '0;
               inflight_d   = 1'b0;
               count_d      = 2'd0;
               wr_ptr_d     = 1'b0;
               rd_ptr_d     = 1'b0;
               err_cnt_d    = '0;
               first_err_d  = '0;
            end
         end
         S_RUN: begin
            if (abort) begin
               // Counters keep their values so the NIOS can inspect a partial run.
               state_d    = S_IDLE;
               inflight_d = 1'b0;
               count_d    = 2'd0;
               wr_ptr_d   = 1'b0;
               rd_ptr_d   = 1'b0;
            end else begin
               inflight_d = issue;
               if (issue) begin
                  issue_addr_d = issue_addr_q + 1'b1;
               end
               if (push) begin
                  wr_ptr_d   = !wr_ptr_q;
                  ret_addr_d = ret_addr_q + 1'b1;
                  if (word_bad) begin
                     if (err_cnt_q != MAX_ERRS) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                     end
                     if (err_cnt_q == '0) begin
                        first_err_d = ret_addr_q;
                     end
                  end
               end
               if (pop) begin
                  rd_ptr_d = !rd_ptr_q;
                  if (head.eop) begin
                     state_d = S_DONE;
                  end
               end
               count_d = count_q + 2'(push) - 2'(pop);
            end
         end
         S_DONE: begin
            if (ack) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         issue_addr_q <= '0;
         ret_addr_q   <= '0;
         inflight_q   <= 1'b0;
         count_q      <= 2'd0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         err_cnt_q    <= '0;
         first_err_q  <= '0;
      end else begin
         state_q      <= state_d;
         issue_addr_q <= issue_addr_d;
         ret_addr_q   <= ret_addr_d;
         inflight_q   <= inflight_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         err_cnt_q    <= err_cnt_d;
         first_err_q  <= first_err_d;
      end
   end

   // NOTE: FIFO storage is not reset; its contents are only visible through the
   // outputs while count_q says the slot is occupied.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= push_entry;
      end
   end

   always_comb begin
      case (state_q)
         S_RUN:   pccm_rsp_con_export = 4'h2;
         S_DONE:  pccm_rsp_con_export = (err_cnt_q == '0) ? 4'h4 : 4'h8;
         default: pccm_rsp_con_export = 4'h0;
      endcase
   end

   assign pcm_mem_mm_address    = issue_addr_q[ADDR_W-1:0];
   assign pcm_mem_mm_chipselect = issue;
   assign pcm_mem_mm_clken      = 1'b1;
   assign pcm_mem_mm_write      = 1'b0;
   assign pcm_mem_mm_writedata  = '0;
   assign pcm_mem_mm_byteenable = 2'b11;

   assign pcm_st_valid = not_empty;
   assign pcm_st_data  = not_empty ? head.data : '0;
   assign pcm_st_sop   = not_empty && head.sop;
   assign pcm_st_eop   = not_empty && head.eop;

   assign mismatch_count = err_cnt_q;
   assign first_err_addr = first_err_q;

endmodule

// File: doc/pcm_mem_reader.md
# pcm_mem_reader

- Read-back counterpart of the PCCM memory fill engine.
- Under NIOS control via the 4-bit PIO control/response pair, it reads all 2048 16-bit words of the PCM on-chip memory in address order.
- It streams the words out on a ready/valid source with packet delimiters.
- It checks each word against the fill pattern (0x0705 at even addresses, 0x0806 at odd addresses) and reports a pass or mismatch status to the NIOS.

## Interface
Parameters:
- ADDR_W, 11, memory address width.
- DATA_W, 16, memory and stream data width.
- PAT_EVEN, 16'h0705, expected word at even addresses.
- PAT_ODD, 16'h0806, expected word at odd addresses.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  reset, asynchronous and active-low (0 = reset).
- pccm_ctl_con_export  in  4  NIOS command: 4'h2 start, 4'h4 acknowledge, 4'h8 abort; all other values are ignored.
- pccm_rsp_con_export  out  4  status: 4'h0 idle, 4'h2 busy, 4'h4 done/pass, 4'h8 done/mismatch.
- pcm_mem_mm_address  out  ADDR_W  read address.
- pcm_mem_mm_chipselect  out  1  high only in cycles that issue a read.
- pcm_mem_mm_clken  out  1  constant 1.
- pcm_mem_mm_write  out  1  constant 0.
- pcm_mem_mm_readdata  in  DATA_W  read data, valid exactly 1 cycle after the chipselect cycle.
- pcm_mem_mm_writedata  out  DATA_W  constant 0.
- pcm_mem_mm_byteenable  out  2  constant 2'b11.
- pcm_st_data  out  DATA_W  stream word.
- pcm_st_valid  out  1  stream word valid.
- pcm_st_ready  in  1  sink ready.
- pcm_st_sop  out  1  high with the word from address 0.
- pcm_st_eop  out  1  high with the word from address 2047.
- mismatch_count  out  12  number of mismatching words in the current/last run.
- first_err_addr  out  ADDR_W  address of the first mismatch; meaningful only when mismatch_count != 0.

## Operation

**States:** IDLE, RUN, DONE.
- IDLE -> RUN when pccm_ctl_con_export == 4'h2.
  - On entry to RUN, clear the issue address, the return address, mismatch_count, first_err_addr and the buffer.
- RUN -> DONE in the cycle after the handshake (valid & ready) of word 2047.
- RUN -> IDLE on command 4'h8 (abort), with priority over all other RUN activity.
  - Abort flushes the buffer immediately.
  - Any read already in flight is discarded.
  - mismatch_count and first_err_addr hold their values.
- DONE -> IDLE on command 4'h4. All other commands are ignored in DONE.
- Start is level-sensitive and recognised only in IDLE. A held 4'h2 after an acknowledge restarts the run.

**Response by state:**
- IDLE: 4'h0.
- RUN: 4'h2.
- DONE: 4'h4 if mismatch_count == 0, else 4'h8.

**Read issue:**
- A 2-entry FIFO holds returned words.
- A read issues in a RUN cycle iff:
  - words remain to be issued (issue address has not passed 2047), and
  - (FIFO occupancy + in-flight reads − pop this cycle) ≤ 1.
- Issue cycle: chipselect = 1, address = issue address, and the issue address increments.
- The issue address does not wrap; no read is issued beyond 2047.

**Return:**
- readdata is captured into the FIFO in the cycle after the issue.
- The return address increments on each captured word.

**Check at capture:**
- Expected value is PAT_EVEN if return address[0] == 0, else PAT_ODD.
- On mismatch, mismatch_count increments by 1. Its maximum is 2048, so it never wraps.
- The first mismatch loads first_err_addr.

**Stream:**
- pcm_st_valid = FIFO not empty.
- pcm_st_data, pcm_st_sop and pcm_st_eop come from the FIFO head.
- The head is popped on valid & ready.
- data, sop and eop are held stable while valid is high and ready is low.

## Timing

**Reset values:**
- pccm_rsp_con_export = 0, pcm_mem_mm_address = 0, pcm_mem_mm_chipselect = 0.
- pcm_st_valid = 0, pcm_st_sop = 0, pcm_st_eop = 0, pcm_st_data = 0.
- mismatch_count = 0, first_err_addr = 0.
- State = IDLE.

**Reset mid-run:** returns every output above to its reset value asynchronously; the FIFO and in-flight read are discarded.

**Start latency (cycle 0 = first clock edge that samples 4'h2):**
- Cycle 1: state RUN, response 4'h2, read of address 0 issued.
- Cycle 2: data returned from memory.
- Cycle 3: pcm_st_valid = 1 with sop = 1.

**Throughput with ready held high:**
- One word per cycle.
- eop word is valid in cycle 2050.
- DONE (response 4'h4/4'h8) from cycle 2051.

**Back-pressure:**
- With ready low, the FIFO fills to 2 and issue stops.
- No word is lost or duplicated.
- Issue resumes in the same cycle ready rises.

**Simultaneous push and pop with a full FIFO:** legal; occupancy stays at 2.

## Test plan
- Memory preloaded with alternating 0x0705/0x0806, ready = 1, cmd 4'h2 → 2048 words in order; sop on the first word, eop on the last; first valid at cycle 3, DONE at cycle 2051; response 4'h4; mismatch_count = 0.
- Address 5 holds 0x0000 and address 1000 holds 0xFFFF → response 4'h8; mismatch_count = 2; first_err_addr = 5; both corrupt words are still streamed.
- Random ready with about 30% duty → identical word sequence to the ready = 1 run; never more than 2 reads outstanding+buffered; data held stable while stalled.
- Abort 4'h8 at word 700 → response 4'h0 next cycle; valid drops; a following start re-reads from address 0 with counters cleared.
- In DONE, send 4'h2 → stays DONE; send 4'h4 → IDLE with response 4'h0.
- Assert reset low mid-run at word 300 → all outputs immediately at reset values; after release, IDLE with response 4'h0.
